// File: rtl/is_result_checker.sv
// is_result_checker: compares N golden array-output lanes against N faulty lanes
// over a programmable window (skip fill cycles, then compare cycles) and captures
// sticky per-lane flags, a saturating error count and the first mismatch.
// Latency: results update on the edge ending each compared cycle (1 cycle).
// Backpressure: none; lanes are sampled every cycle, start is a one-cycle pulse.
// Ports: clk, rst (async, active-high); start, abort, skip_cycles, cmp_cycles;
//        m2_gold/m2_fault (N lanes of 2*D_W); busy, done, mismatch_any,
//        mismatch_mask, err_count, first_cycle, first_lane, first_gold, first_fault.
// Optional: define IS_CHK_SIGNATURE_EN to add gold_sig, a 32-bit running sum of
//           all golden lanes over every compare cycle.
module is_result_checker #(
    parameter int D_W = 8,
    parameter int N   = 8,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [7:0]                skip_cycles,
    input  logic [15:0]               cmp_cycles,
    input  logic [N-1:0][2*D_W-1:0]   m2_gold,
    input  logic [N-1:0][2*D_W-1:0]   m2_fault,
    output logic                      busy,
    output logic                      done,
    output logic                      mismatch_any,
    output logic [N-1:0]              mismatch_mask,
    output logic [15:0]               err_count,
    output logic [15:0]               first_cycle,
    output logic [CW-1:0]             first_lane,
    output logic [2*D_W-1:0]          first_gold,
    output logic [2*D_W-1:0]          first_fault
`ifdef IS_CHK_SIGNATURE_EN
    ,
    output logic [31:0]               gold_sig
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [7:0]    skip_cnt;   // remaining fill cycles
    logic [15:0]   cmp_len;    // compare window length captured at start
    logic [15:0]   cmp_idx;    // index of the current compare cycle

    logic              accept;
    logic              cmp_en;
    logic [N-1:0]      diff;
    logic [15:0]       pop;
    logic [16:0]       err_sum;
    logic [15:0]       err_next;
    logic [CW-1:0]     low_lane;
    logic [2*D_W-1:0]  low_gold;
    logic [2*D_W-1:0]  low_fault;

    assign accept = start && !abort && (state == IDLE || state == DONE);
    // An aborting cycle is not compared so the held results are exactly the
    // ones captured before the abort.
    assign cmp_en = (state == COMPARE) && !abort;

    assign busy = (state == SKIP) || (state == COMPARE);
    assign done = (state == DONE);

    // Lane comparison, popcount and lowest mismatching lane.
    always_comb begin
        diff      = '0;
        pop       = '0;
        low_lane  = '0;
        low_gold  = '0;
        low_fault = '0;
        for (int r = 0; r < N; r++) begin
            diff[r] = (m2_gold[r] != m2_fault[r]);
            pop     = pop + 16'(diff[r]);
        end
        // Walk downwards so the lowest mismatching lane wins.
        for (int r = N - 1; r >= 0; r--) begin
            if (diff[r]) begin
                low_lane  = CW'(r);
                low_gold  = m2_gold[r];
                low_fault = m2_fault[r];
            end
        end
        err_sum  = {1'b0, err_count} + {1'b0, pop};
        err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    if (skip_cycles != 8'd0)      state_n = SKIP;
                    else if (cmp_cycles != 16'd0) state_n = COMPARE;
                    else                          state_n = DONE;
                end
            end
            SKIP: begin
                if (skip_cnt == 8'd1) state_n = (cmp_len != 16'd0) ? COMPARE : DONE;
            end
            COMPARE: begin
                if (cmp_idx == cmp_len - 16'd1) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_cnt      <= '0;
            cmp_len       <= '0;
            cmp_idx       <= '0;
            mismatch_any  <= 1'b0;
            mismatch_mask <= '0;
            err_count     <= '0;
            first_cycle   <= '0;
            first_lane    <= '0;
            first_gold    <= '0;
            first_fault   <= '0;
        end else if (accept) begin
            skip_cnt      <= skip_cycles;
            cmp_len       <= cmp_cycles;
            cmp_idx       <= '0;
            mismatch_any  <= 1'b0;
            mismatch_mask <= '0;
            err_count     <= '0;
            first_cycle   <= '0;
            first_lane    <= '0;
            first_gold    <= '0;
            first_fault   <= '0;
        end else begin
            if (state == SKIP && !abort) skip_cnt <= skip_cnt - 8'd1;
            if (cmp_en) begin
                cmp_idx       <= cmp_idx + 16'd1;
                mismatch_mask <= mismatch_mask | diff;
                err_count     <= err_next;
                if (|diff) begin
                    mismatch_any <= 1'b1;
                    // First mismatch is latched once per run.
                    if (!mismatch_any) begin
                        first_cycle <= cmp_idx;
                        first_lane  <= low_lane;
                        first_gold  <= low_gold;
                        first_fault <= low_fault;
                    end
                end
            end
        end
    end

`ifdef IS_CHK_SIGNATURE_EN
    logic [31:0] lane_sum;

    always_comb begin
        lane_sum = '0;
        for (int r = 0; r < N; r++) lane_sum = lane_sum + 32'(m2_gold[r]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         gold_sig <= '0;
        else if (accept) gold_sig <= '0;
        else if (cmp_en) gold_sig <= gold_sig + lane_sum;
    end
`endif

endmodule

// File: doc/is_result_checker.md
IS_RESULT_CHECKER -- requirements
Module: is_result_checker

Interface
REQ-001 Parameter D_W, default 8: operand width; result lanes are 2*D_W bits wide.
REQ-002 Parameter N, default 8: number of result lanes (array rows); CW = clog2(N), minimum 1.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse that arms a compare run; honoured only in IDLE or DONE.
REQ-006 abort  in  1  forces a return to IDLE; captured results are held.
REQ-007 skip_cycles  in  8  pipeline-fill cycles ignored before comparing; sampled on an accepted start.
REQ-008 cmp_cycles  in  16  number of compare cycles; sampled on an accepted start.
REQ-009 m2_gold  in  N x 2*D_W  golden array outputs, lane r = row r.
REQ-010 m2_fault  in  N x 2*D_W  faulty array outputs, lane r = row r.
REQ-011 busy  out  1  high in SKIP or COMPARE.
REQ-012 done  out  1  high in DONE.
REQ-013 mismatch_any  out  1  sticky; set by any lane mismatch in COMPARE.
REQ-014 mismatch_mask  out  N  sticky per-lane mismatch flags.
REQ-015 err_count  out  16  saturating count of mismatching lane-cycles.
REQ-016 first_cycle  out  16  compare-cycle index (0-based) of the first mismatch.
REQ-017 first_lane  out  CW  lowest mismatching lane in the first mismatching cycle.
REQ-018 first_gold, first_fault  out  2*D_W each  lane values captured at the first mismatch.

Function
REQ-019 FSM states: IDLE, SKIP, COMPARE, DONE.
REQ-020 Accepted start clears all result outputs and loads both counters; the next state is SKIP, or COMPARE if skip_cycles == 0, or DONE if both counts are 0.
REQ-021 SKIP: lane inputs are ignored for exactly skip_cycles cycles, then the FSM moves to COMPARE.
REQ-022 COMPARE: all N lanes are compared every cycle with a bitwise inequality test, for exactly cmp_cycles cycles, then the FSM moves to DONE.
REQ-023 Per compare cycle, err_count increases by the popcount of mismatching lanes and saturates at 0xFFFF.
REQ-024 On the first mismatching cycle, the block latches first_cycle, first_lane, first_gold and first_fault once; later mismatches do not update them.
REQ-025 Result registers are updated on the edge that ends the compared cycle, giving 1-cycle latency from the inputs.
REQ-026 DONE holds all results until an accepted start or abort.
REQ-027 start is ignored in SKIP or COMPARE.
REQ-028 abort has priority over start in the same cycle: the FSM goes to IDLE and results are not cleared.
REQ-029 Lane inputs presented in IDLE or DONE have no effect.
REQ-030 busy and done are decoded from state registers only, with no combinational input paths.

Reset
REQ-031 rst asserted, including mid-run, forces IDLE immediately (asynchronous).
REQ-032 Under reset, busy, done, mismatch_any and mismatch_mask are 0.
REQ-033 Under reset, err_count, first_cycle, first_lane, first_gold, first_fault and the internal counters are 0.

Configuration
REQ-034 Macro IS_CHK_SIGNATURE_EN, when defined, adds output gold_sig (32 bits): the sum modulo 2^32 of all N zero-extended m2_gold lanes over every COMPARE cycle.
REQ-035 With IS_CHK_SIGNATURE_EN defined, gold_sig is cleared by reset and by an accepted start, and is held in DONE.
REQ-036 With IS_CHK_SIGNATURE_EN undefined, gold_sig and its adder are absent and all other behaviour is identical.

Verification
REQ-037 Identical lanes, skip=3, cmp=10 -> busy for 13 cycles, then done=1, err_count=0, mismatch_mask=0.
REQ-038 Lane 5 differs (gold 0x0040, fault 0x0041) only at compare cycle 4 -> err_count=1, mask=0x20, first_cycle=4, first_lane=5, first_gold=0x0040, first_fault=0x0041.
REQ-039 Lanes 2 and 6 differ at cycle 0 and lane 1 differs at cycle 7 -> err_count=3, mask=0x46, first_cycle=0, first_lane=2.
REQ-040 Mismatch only during SKIP, or only after DONE -> err_count=0 and mismatch_any=0.
REQ-041 All 8 lanes differ for cmp=0xFFFF -> err_count saturates at 0xFFFF; rst pulsed mid-run -> immediate IDLE with all outputs 0.
REQ-042 With IS_CHK_SIGNATURE_EN defined: all lanes 0x0001, cmp=4 -> gold_sig=32; start and abort in the same cycle -> IDLE with prior results retained.
